// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared types for the lc3b pipeline stage registers
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    // Decode/execute bundle; field order fixes the bit layout seen downstream.
    typedef struct packed {
        logic [15:0] npc;
        logic [9:0]  cw;
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [2:0]  cc;
        logic [2:0]  dr;
    } lc3b_de_ex_t;

    localparam int DE_EX_W = $bits(lc3b_de_ex_t);

    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            PS_BUSY: return 2'd1;
            PS_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush, optional skid slot and stall counter
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = DE_EX_W,
    parameter int SKID  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic accept;
    logic issue;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    // Counts downstream back-pressure only; flush does not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    if (SKID == 0) begin : g_single

        assign in_ready  = ~reset & ~flush & (~out_valid | out_ready);
        assign occupancy = {1'b0, out_valid};

        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (issue) begin
                out_valid <= 1'b0;
            end
        end

    end else begin : g_skid

        pipe_state_t      state;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        // in_ready depends only on state, so out_ready never reaches upstream combinationally.
        assign in_ready  = ~reset & ~flush & (state != PS_FULL);
        assign out_valid = (state != PS_EMPTY);
        assign out_data  = main_q;
        assign occupancy = occ_of(state);

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= PS_EMPTY;
                main_q <= '0;
                skid_q <= '0;
            end else if (flush) begin
                state <= PS_EMPTY;
            end else begin
                case (state)
                    PS_EMPTY: begin
                        if (accept) begin
                            main_q <= in_data;
                            state  <= PS_BUSY;
                        end
                    end
                    PS_BUSY: begin
                        if (accept && issue) begin
                            main_q <= in_data;
                        end else if (accept) begin
                            skid_q <= in_data;
                            state  <= PS_FULL;
                        end else if (issue) begin
                            state <= PS_EMPTY;
                        end
                    end
                    PS_FULL: begin
                        if (issue) begin
                            main_q <= skid_q;
                            state  <= PS_BUSY;
                        end
                    end
                    default: state <= PS_EMPTY;
                endcase
            end
        end

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboarded checks of pipe_stage_reg for SKID=0/1 and a 3-bit counter
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  fl, iv, ir, ov, ordy;
    logic [15:0] id  [3];
    logic [15:0] od  [3];
    logic [1:0]  occ [3];
    logic [15:0] sc0, sc1;
    logic [2:0]  sc2;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb [2][0:4095];
    int wr [2];
    int rd [2];

    pipe_stage_reg #(.WIDTH(16), .SKID(0), .CNT_W(16)) u_single (
        .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc0));

    pipe_stage_reg #(.WIDTH(16), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc1));

    pipe_stage_reg #(.WIDTH(16), .SKID(1), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cnt(sc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sc_of(input int k);
        if (k == 0) return sc0;
        if (k == 1) return sc1;
        return {13'd0, sc2};
    endfunction

    initial begin
        reset = 1'b1;
        fl    = 3'b000;
        iv    = 3'b111;
        ordy  = 3'b111;
        for (int k = 0; k < 3; k++) id[k] = 16'h1234;
        edge_step();
        edge_step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset.in_ready[%0d]", k), ir[k], 0);
            chk($sformatf("reset.out_valid[%0d]", k), ov[k], 0);
            chk($sformatf("reset.out_data[%0d]", k), od[k], 0);
            chk($sformatf("reset.stall_cnt[%0d]", k), sc_of(k), 0);
            chk($sformatf("reset.occupancy[%0d]", k), occ[k], 0);
        end
        edge_step();
        reset = 1'b0;
        iv    = 3'b000;

        // back-to-back stream, each word one cycle after it is offered
        for (int k = 0; k < 2; k++) begin
            ordy[k] = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                iv[k] = 1'b1;
                id[k] = 16'(i);
                @(negedge clk);
                chk($sformatf("stream%0d.in_ready[%0d]", k, i), ir[k], 1);
                if (i > 1) begin
                    chk($sformatf("stream%0d.out_valid[%0d]", k, i), ov[k], 1);
                    chk($sformatf("stream%0d.out_data[%0d]", k, i), od[k], i - 1);
                end
                edge_step();
            end
            iv[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("stream%0d.last_data", k), od[k], 16'h0008);
            chk($sformatf("stream%0d.last_valid", k), ov[k], 1);
            edge_step();
            @(negedge clk);
            chk($sformatf("stream%0d.drained", k), ov[k], 0);
            chk($sformatf("stream%0d.occupancy", k), occ[k], 0);
            edge_step();
        end

        // five stall cycles with AAAA held, BBBB behind it
        for (int k = 0; k < 2; k++) begin
            ordy[k] = 1'b0;
            iv[k]   = 1'b1;
            id[k]   = 16'hAAAA;
            @(negedge clk);
            chk($sformatf("stall%0d.first_ready", k), ir[k], 1);
            edge_step();
            for (int c = 1; c <= 5; c++) begin
                iv[k] = (k == 0 || c == 1);
                id[k] = 16'hBBBB;
                @(negedge clk);
                chk($sformatf("stall%0d.hold_data[%0d]", k, c), od[k], 16'hAAAA);
                chk($sformatf("stall%0d.hold_valid[%0d]", k, c), ov[k], 1);
                if (k == 0) begin
                    chk($sformatf("stall%0d.in_ready[%0d]", k, c), ir[k], 0);
                    chk($sformatf("stall%0d.occupancy[%0d]", k, c), occ[k], 1);
                end else if (c > 1) begin
                    chk($sformatf("stall%0d.in_ready[%0d]", k, c), ir[k], 0);
                    chk($sformatf("stall%0d.occupancy[%0d]", k, c), occ[k], 2);
                end
                edge_step();
            end
            ordy[k] = 1'b1;
            iv[k]   = (k == 0);
            @(negedge clk);
            chk($sformatf("stall%0d.release_a", k), od[k], 16'hAAAA);
            edge_step();
            iv[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("stall%0d.release_b", k), od[k], 16'hBBBB);
            chk($sformatf("stall%0d.release_b_valid", k), ov[k], 1);
            chk($sformatf("stall%0d.stall_cnt", k), sc_of(k), 5);
            edge_step();
            @(negedge clk);
            chk($sformatf("stall%0d.empty", k), ov[k], 0);
            edge_step();
        end

        // flush while holding entries and offering CCCC
        for (int k = 0; k < 2; k++) begin
            ordy[k] = 1'b0;
            iv[k]   = 1'b1;
            id[k]   = 16'h1111;
            @(negedge clk);
            edge_step();
            id[k] = 16'h2222;
            @(negedge clk);
            edge_step();
            fl[k]   = 1'b1;
            id[k]   = 16'hCCCC;
            ordy[k] = 1'b1;
            @(negedge clk);
            chk($sformatf("flush%0d.in_ready", k), ir[k], 0);
            chk($sformatf("flush%0d.occ_before", k), occ[k], (k == 0) ? 1 : 2);
            edge_step();
            fl[k] = 1'b0;
            iv[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("flush%0d.out_valid", k), ov[k], 0);
            chk($sformatf("flush%0d.occ_after", k), occ[k], 0);
            chk($sformatf("flush%0d.payload_held", k), od[k], 16'h1111);
            chk($sformatf("flush%0d.stall_cnt", k), sc_of(k), 6);
            edge_step();
            @(negedge clk);
            chk($sformatf("flush%0d.no_cccc", k), ov[k], 0);
            edge_step();
        end

        // 3-bit counter saturates at 7
        ordy[2] = 1'b0;
        iv[2]   = 1'b1;
        id[2]   = 16'h5A5A;
        @(negedge clk);
        edge_step();
        iv[2] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("sat.stall_cnt[%0d]", c), sc2, (c - 1 > 7) ? 7 : c - 1);
            chk($sformatf("sat.data[%0d]", c), od[2], 16'h5A5A);
            edge_step();
        end
        ordy[2] = 1'b1;
        @(negedge clk);
        edge_step();
        @(negedge clk);
        chk("sat.drained", ov[2], 0);
        chk("sat.hold_after", sc2, 7);
        edge_step();

        // random valid/ready against an in-order scoreboard
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0;
            rd[k] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = 1'($urandom_range(0, 1));
                id[k]   = 16'($urandom);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    if (rd[k] == wr[k])
                        chk($sformatf("rnd%0d.spurious[%0d]", k, n), ov[k], 0);
                    else
                        chk($sformatf("rnd%0d.data[%0d]", k, n), od[k], sb[k][rd[k]]);
                end
                if (ov[k] && ordy[k]) rd[k]++;
                if (iv[k] && ir[k]) begin
                    sb[k][wr[k]] = id[k];
                    wr[k]++;
                end
            end
            edge_step();
        end
        iv   = 3'b000;
        ordy = 3'b111;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    if (rd[k] == wr[k])
                        chk($sformatf("drain%0d.spurious", k), ov[k], 0);
                    else
                        chk($sformatf("drain%0d.data", k), od[k], sb[k][rd[k]]);
                    rd[k]++;
                end
            end
            edge_step();
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rnd%0d.final_valid", k), ov[k], 0);
            chk($sformatf("rnd%0d.count", k), rd[k], wr[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
